serializador: RTL
=================

// Module: serializador
// PURPOSE
// - Upstream stage feeding the deserializer. Accepts parallel bytes from a host
//   and shifts them out one bit per cycle, MSB first, on bit_out.
// - Each bit is qualified by a one-cycle write_out strobe. These outputs connect
//   to the deserializer's data_in/write_in.
// - Pauses whenever the deserializer raises status_in (byte pending, awaiting ack).
// - Double-buffered: one holding register plus one shift register. A new byte can
//   be accepted while the previous one is still shifting.
// PARAMETERS
// - DATA_WIDTH  8  bits per word. Shift register and holding register width.
// - GAP_CYCLES  1  idle cycles (write_out=0) inserted after each word. Legal range 1..15.
// PORTS
// - clk_100KHz      in   1           sole clock, rising edge; same domain as deserializer
// - reset           in   1           asynchronous, active-high; clears all state
// - data_in         in   DATA_WIDTH  parallel word to send
// - send_in         in   1           request: capture data_in when ready_out=1
// - ready_out       out  1           holding register empty; send_in is accepted
// - status_in       in   1           deserializer busy; 1 = do not emit a bit this cycle
// - bit_out         out  1           serial data bit, valid when write_out=1
// - write_out       out  1           bit strobe; high exactly one cycle per bit
// - busy_out        out  1           FSM not in IDLE
// - sent_count_out  out  8           words fully sent, modulo 256
// BEHAVIOUR
// - Reset values: ready_out=1; bit_out=0; write_out=0; busy_out=0; sent_count_out=0;
//   FSM=IDLE; hold_valid=0; bit_cnt=0. All outputs are registered.
// - Accept: on an edge with send_in=1 and ready_out=1, hold<=data_in and hold_valid<=1.
//   - send_in while ready_out=0 is ignored; no error flag.
//   - ready_out = !hold_valid.
// - FSM IDLE:
//   - hold_valid=1 and status_in=0: shift<=hold<<1, bit_out<=hold[MSB],
//     write_out<=1, bit_cnt<=1, hold_valid<=0, go SHIFT.
//   - Otherwise write_out<=0.
// - FSM SHIFT:
//   - status_in=0: bit_out<=shift[MSB], write_out<=1, shift<<=1, bit_cnt++.
//   - status_in=1: write_out<=0, shift/bit_cnt frozen. The bit is neither lost
//     nor duplicated.
//   - After emitting bit DATA_WIDTH: sent_count_out++ (255 wraps to 0), go GAP,
//     gap_cnt<=GAP_CYCLES.
// - FSM GAP: write_out<=0; gap_cnt-- each cycle; go IDLE when gap_cnt reaches 1.
//   status_in is ignored in GAP.
// - Latency: word accepted at edge k in IDLE with status_in=0 gives its first bit
//   visible after edge k+1. With no stalls, the bits occupy cycles k+1..k+DATA_WIDTH.
// - Simultaneous load and accept: hold is emptied (loaded into shift) at the same
//   edge send_in arrives, but ready_out was 0 before that edge, so the word is not
//   accepted. The host retries next cycle.
// - Accept during SHIFT/GAP is allowed (double buffering). The held word starts on
//   the first IDLE cycle with status_in=0.
// - Reset mid-word: the partial word and the held word are discarded, and outputs
//   go to reset values immediately (asynchronous). The downstream deserializer
//   shares the reset, so no partial word survives.
// - bit_out holds its last value while write_out=0. Consumers must use write_out only.
// TESTING
// - Reset: after reset, ready_out=1, write_out=0, busy_out=0, sent_count_out=0.
// - Single word 0xA5, status_in=0: bit_out=1,0,1,0,0,1,0,1 on 8 consecutive
//   write_out cycles. Then GAP_CYCLES idle cycles; sent_count_out=1.
// - Back-to-back 0x3C then 0xC3:
//   - 0xC3 is accepted while 0x3C is shifting.
//   - Stream is 00111100, then exactly GAP_CYCLES low cycles, then 11000011.
//   - sent_count_out=2.
// - Stall: status_in=1 for 3 cycles after bit 4 of 0xF0. write_out is low for those
//   3 cycles, then bits 5..8 are 0,0,0,0. Total of 8 strobes, none duplicated.
// - Reset after 4 bits of 0xFF: outputs clear at once. A following word 0x81 is
//   sent whole as 10000001, and sent_count_out=1.
// - Wrap: send 256 words; sent_count_out returns to 0 and ready_out/handshake
//   stay correct throughout.

Source files
------------

// File: rtl/serializador.sv
// serializador: parallel-to-serial stage feeding the deserializer.
// Bytes from the host land in a holding register, move into a shift register
// and leave MSB first on bit_out, one bit per write_out strobe. Emission pauses
// while the downstream deserializer raises status_in, and every word is followed
// by GAP_CYCLES idle cycles.
//
// Host handshake: send_in/data_in are captured on a rising edge only when
// ready_out is 1 at that edge. ready_out is registered and equals "holding
// register empty", so a word that empties the holding register at the same edge
// a new send_in arrives is not replaced; the host simply retries next cycle.
// A send_in seen while ready_out=0 has no effect.
//
// Downstream strobe: write_out is high for exactly one cycle per emitted bit.
// bit_out only carries meaning while write_out=1; otherwise it keeps its last
// value. A status_in=1 sampled at an edge suppresses emission at that edge
// without losing or repeating the pending bit.
module serializador #(
   parameter int DATA_WIDTH = 8,
   parameter int GAP_CYCLES = 1   // legal range 1..15
) (
   input  logic                  clk_100KHz,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  send_in,
   output logic                  ready_out,
   input  logic                  status_in,
   output logic                  bit_out,
   output logic                  write_out,
   output logic                  busy_out,
   output logic [7:0]            sent_count_out,
   output logic [1:0]            fsm_state       // 0 = IDLE, 1 = SHIFT, 2 = GAP
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam int MSB   = DATA_WIDTH - 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t                state;
   state_t                state_nxt;

   logic [DATA_WIDTH-1:0] hold;
   logic [DATA_WIDTH-1:0] hold_nxt;
   logic                  hold_valid;
   logic                  hold_valid_nxt;
   logic [DATA_WIDTH-1:0] shift;
   logic [DATA_WIDTH-1:0] shift_nxt;
   logic [CNT_W-1:0]      bit_cnt;
   logic [CNT_W-1:0]      bit_cnt_nxt;
   logic [3:0]            gap_cnt;
   logic [3:0]            gap_cnt_nxt;
   logic                  bit_nxt;
   logic                  write_nxt;
   logic [7:0]            sent_nxt;

   logic                  accept;
   logic                  load;
   logic                  emit;
   logic                  last_bit;

   // ready_out mirrors !hold_valid, so accept can never coincide with load
   assign accept   = send_in & ready_out;
   assign load     = (state == IDLE) & hold_valid & ~status_in;
   assign emit     = (state == SHIFT) & ~status_in;
   assign last_bit = emit & (bit_cnt == CNT_W'(DATA_WIDTH - 1));

   assign fsm_state = state;

   // state register
   always_ff @(posedge clk_100KHz or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state decision: start on a held word, finish after the last bit, wait out the gap
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (load) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (last_bit) begin
               state_nxt = GAP;
            end
         end
         GAP: begin
            if (gap_cnt <= 4'd1) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // datapath and output values for the coming edge
   always_comb begin
      hold_nxt       = hold;
      hold_valid_nxt = hold_valid;
      shift_nxt      = shift;
      bit_cnt_nxt    = bit_cnt;
      gap_cnt_nxt    = gap_cnt;
      bit_nxt        = bit_out;
      write_nxt      = 1'b0;
      sent_nxt       = sent_count_out;

      if (accept) begin
         hold_nxt       = data_in;
         hold_valid_nxt = 1'b1;
      end

      unique case (state)
         IDLE: begin
            // first bit leaves straight from the holding register
            if (load) begin
               shift_nxt      = hold << 1;
               bit_nxt        = hold[MSB];
               write_nxt      = 1'b1;
               bit_cnt_nxt    = CNT_W'(1);
               hold_valid_nxt = 1'b0;
            end
         end
         SHIFT: begin
            // a stalled cycle leaves shift and bit_cnt untouched
            if (emit) begin
               bit_nxt     = shift[MSB];
               write_nxt   = 1'b1;
               shift_nxt   = shift << 1;
               bit_cnt_nxt = bit_cnt + CNT_W'(1);
               if (last_bit) begin
                  sent_nxt    = sent_count_out + 8'd1;
                  gap_cnt_nxt = 4'(GAP_CYCLES);
               end
            end
         end
         GAP: begin
            if (gap_cnt != 4'd0) begin
               gap_cnt_nxt = gap_cnt - 4'd1;
            end
         end
         default: begin
            write_nxt = 1'b0;
         end
      endcase
   end

   // registered datapath and outputs; reset discards any partial or held word
   always_ff @(posedge clk_100KHz or posedge reset) begin
      if (reset) begin
         hold           <= '0;
         hold_valid     <= 1'b0;
         shift          <= '0;
         bit_cnt        <= '0;
         gap_cnt        <= '0;
         bit_out        <= 1'b0;
         write_out      <= 1'b0;
         sent_count_out <= 8'd0;
         ready_out      <= 1'b1;
         busy_out       <= 1'b0;
      end else begin
         hold           <= hold_nxt;
         hold_valid     <= hold_valid_nxt;
         shift          <= shift_nxt;
         bit_cnt        <= bit_cnt_nxt;
         gap_cnt        <= gap_cnt_nxt;
         bit_out        <= bit_nxt;
         write_out      <= write_nxt;
         sent_count_out <= sent_nxt;
         ready_out      <= ~hold_valid_nxt;
         busy_out       <= (state_nxt != IDLE);
      end
   end

endmodule
